softmax_vec_packer: RTL and testbench
=====================================

Name: softmax_vec_packer

Overview:
- Front-end producer for the N-lane Q4.12 softmax datapath.
- Accepts a serial stream of Q4.12 scores one element per cycle and packs each row into the flat vector the softmax consumes.
- Computes the row maximum on the fly and issues vector, maximum and a one-cycle valid strobe, which drive softmax in_x_flat / max_x / valid_in directly.
- Short rows, terminated by in_last before N elements, are padded so padded lanes contribute ~0 probability.

Parameters:
- N, 8, number of lanes per softmax row; N >= 2.
- PAD_VAL, 16'h8000, Q4.12 fill value for unused lanes (-8.0, most negative).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  global pipeline enable; 0 freezes all state.
- in_valid  input  1  in_data/in_last carry an element this cycle.
- in_data  input  16  signed Q4.12 score.
- in_last  input  1  marks final element of the current row.
- in_ready  output  1  block can accept an element; equals en (combinational).
- out_x_flat  output  N*16  packed row; lane k at [16*k +: 16]; lane 0 = first element streamed.
- out_max_x  output  16  signed maximum of the valid lanes of the row.
- out_len  output  $clog2(N)+1  number of real (non-pad) lanes, 1..N.
- out_valid  output  1  one-cycle strobe; out_x_flat/out_max_x/out_len valid.

Behaviour:
- Reset: rst=1 at a clock edge takes priority over en. It clears the collect buffer, lane count and running max, and discards any partial row. Outputs reset to out_x_flat=0, out_max_x=0, out_len=0, out_valid=0.
- Accept condition: in_valid && in_ready (in_ready=en). in_data and in_last are ignored when not accepted.
- Collect state: lane counter cnt (0..N-1) and collect buffer. Accepted element is written to lane cnt.
  - cnt==0: running max := in_data.
  - cnt>0: running max := signed max(running max, in_data); full 16-bit signed compare; ties keep the existing value.
- Row completion: the accepted element has in_last=1, or cnt==N-1 (Nth element); in_last on the Nth element is redundant, not an error. On the completing edge:
  - Output registers load the buffer with this element merged.
  - Lanes cnt+1..N-1 are filled with PAD_VAL.
  - out_max_x loads the final max, excluding pad lanes.
  - out_len := cnt+1.
  - out_valid := 1.
  - cnt := 0.
- Latency: completing element accepted at edge t gives out_valid=1 during cycle t+1 (registered, one cycle after acceptance).
- out_valid: high exactly one enabled cycle per completed row. It falls at the next enabled edge unless that edge completes another row; back-to-back 1-element rows give continuous out_valid.
- Output data hold: out_x_flat/out_max_x/out_len hold their last row until the next completion; they are not cleared when out_valid drops.
- en=0: no acceptance, no counter/buffer/output change. out_valid holds its current value, so a strobe stretches across the stall in lockstep with the downstream softmax, which is frozen by the same en.
- Simultaneous completion and acceptance: new-row collection begins on the edge after completion, with no bubble; the output registers are independent of the collect buffer.
- No backpressure from downstream; maximum issue rate is one row per cycle.

Test Plan:
- Full row: stream 21C3,FDF8,FC4E,EC6E,3521,0501,13BE,EE08 with in_last on the 8th element. Required response, one cycle later: out_valid=1 for one cycle; out_x_flat={EE08,13BE,0501,3521,EC6E,FC4E,FDF8,21C3} (lane7..lane0); out_max_x=3521; out_len=8.
- Equal elements plus back-to-back rows: 8x 0501, then immediately 21C3,FDF8,FC4E,EC6E,4521,0501,13BE,FE08 with no gap.
  - Row 1: out_max_x=0501, all lanes 0501.
  - Row 2: out_max_x=4521, strobe exactly 8 cycles after row 1's strobe.
- Short row: FE08,FC6E,FC4E with in_last on the 3rd element. Required response: lanes0-2=FE08,FC6E,FC4E; lanes3-7=8000; out_max_x=FE08; out_len=3.
- All-negative / single-element rows:
  - Row 8000,FFFF,8001 (in_last on 3rd) -> out_max_x=FFFF.
  - Then 1-element rows 1000 and 2000 on consecutive cycles -> out_valid high 2 consecutive cycles; out_len=1; out_max_x 1000 then 2000.
- en stall: drop en for 3 cycles mid-row (after 4 elements) and again while out_valid=1.
  - in_ready=0 during the stall; in_valid elements are not captured.
  - The row completes with the correct 8 values.
  - out_valid stays high across the stall, then drops after one enabled cycle.
- Reset mid-row: stream 4 elements, assert rst for 1 cycle with en=0, then stream a full row.
  - Outputs are 0 immediately after the reset edge.
  - The first strobe carries only the new row, with lane 0 = first post-reset element.

Source files
------------

// File: rtl/softmax_vec_packer_if.sv
// Stream-in / row-out bus of the softmax vector packer.
// The slave modport is the packer side; the master modport is the score producer and row consumer.
interface softmax_vec_packer_if #(
    parameter int N = 8
);
    localparam int LW = $clog2(N) + 1;

    logic            in_valid;
    logic [15:0]     in_data;
    logic            in_last;
    logic            in_ready;
    logic [N*16-1:0] out_x_flat;
    logic [15:0]     out_max_x;
    logic [LW-1:0]   out_len;
    logic            out_valid;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, out_x_flat, out_max_x, out_len, out_valid
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, out_x_flat, out_max_x, out_len, out_valid
    );
endinterface

// File: rtl/softmax_vec_packer.sv
// Packs a serial Q4.12 score stream into N-lane softmax rows and tracks the row maximum.
// Short rows are padded with PAD_VAL so the unused lanes contribute almost no probability.
module softmax_vec_packer #(
    parameter int          N       = 8,
    parameter logic [15:0] PAD_VAL = 16'h8000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    softmax_vec_packer_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam int LW = CW + 1;

    logic [CW-1:0]       cnt;
    logic [N-1:0][15:0]  row_buf;
    logic [15:0]         run_max;
    logic [15:0]         next_max;
    logic [N*16-1:0]     merged;
    logic                accept;
    logic                complete;

    assign bus.in_ready = en;
    assign accept       = bus.in_valid && en;
    assign complete     = accept && (bus.in_last || (cnt == CW'(N - 1)));

    // Ties keep the existing maximum; lane 0 always restarts the running maximum.
    always_comb begin
        next_max = run_max;
        if (cnt == '0) begin
            next_max = bus.in_data;
        end else if ($signed(bus.in_data) > $signed(run_max)) begin
            next_max = bus.in_data;
        end
    end

    // Row image as it will be issued: collected lanes, the completing element, then padding.
    always_comb begin
        merged = '0;
        for (int k = 0; k < N; k++) begin
            if (k < int'(cnt)) begin
                merged[16*k +: 16] = row_buf[k];
            end else if (k == int'(cnt)) begin
                merged[16*k +: 16] = bus.in_data;
            end else begin
                merged[16*k +: 16] = PAD_VAL;
            end
        end
    end

    // Output registers are separate from the collect buffer, so a new row can start
    // on the very edge that issues the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            row_buf        <= '0;
            run_max        <= '0;
            bus.out_x_flat <= '0;
            bus.out_max_x  <= '0;
            bus.out_len    <= '0;
            bus.out_valid  <= 1'b0;
        end else if (en) begin
            bus.out_valid <= complete;
            if (accept) begin
                row_buf[cnt] <= bus.in_data;
                run_max      <= next_max;
                if (complete) begin
                    bus.out_x_flat <= merged;
                    bus.out_max_x  <= next_max;
                    bus.out_len    <= LW'(cnt) + LW'(1);
                    cnt            <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_softmax_vec_packer.sv
// Self-checking bench for softmax_vec_packer: directed rows from the test plan plus random
// traffic, compared every cycle against a row-level queue model.
module tb_softmax_vec_packer;
    localparam int N = 8;

    logic clk;
    logic rst;
    logic en;

    int checks = 0;
    int errors = 0;

    logic [15:0]    row_q[$];
    logic [N*16-1:0] exp_flat;
    logic [15:0]    exp_max;
    logic [3:0]     exp_len;
    logic           exp_valid;

    softmax_vec_packer_if #(.N(N)) tb_if ();

    softmax_vec_packer #(.N(N), .PAD_VAL(16'h8000)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (tb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Row-level reference: a finished row is the streamed elements, padded, with its plain maximum.
    task automatic issueRow();
        exp_len  = 4'(row_q.size());
        exp_max  = row_q[0];
        exp_flat = '0;
        for (int k = 0; k < N; k++) begin
            if (k < row_q.size()) begin
                exp_flat[16*k +: 16] = row_q[k];
                if ($signed(row_q[k]) > $signed(exp_max)) exp_max = row_q[k];
            end else begin
                exp_flat[16*k +: 16] = 16'h8000;
            end
        end
        exp_valid = 1'b1;
        row_q.delete();
    endtask

    task automatic applyStimulus(input logic e, input logic v, input logic [15:0] d,
                                 input logic l, input logic r);
        en             = e;
        rst            = r;
        tb_if.in_valid = v;
        tb_if.in_data  = d;
        tb_if.in_last  = l;
        #1;
        checkOutput("in_ready", 128'(tb_if.in_ready), 128'(e));
        @(posedge clk);
        if (r) begin
            row_q.delete();
            exp_flat  = '0;
            exp_max   = '0;
            exp_len   = '0;
            exp_valid = 1'b0;
        end else if (e) begin
            exp_valid = 1'b0;
            if (v) begin
                row_q.push_back(d);
                if (l || row_q.size() == N) issueRow();
            end
        end
        #1;
        checkOutput("out_valid",  128'(tb_if.out_valid),  128'(exp_valid));
        checkOutput("out_x_flat", 128'(tb_if.out_x_flat), 128'(exp_flat));
        checkOutput("out_max_x",  128'(tb_if.out_max_x),  128'(exp_max));
        checkOutput("out_len",    128'(tb_if.out_len),    128'(exp_len));
    endtask

    task automatic sendRow(input logic [15:0] vals[8], input int len);
        for (int i = 0; i < len; i++) begin
            applyStimulus(1'b1, 1'b1, vals[i], (i == len - 1), 1'b0);
        end
    endtask

    initial begin
        logic [15:0] r1[8];
        logic [15:0] r2[8];
        logic [15:0] r3[8];
        logic [15:0] r4[8];
        logic [15:0] ones[8];

        r1   = '{16'h21C3, 16'hFDF8, 16'hFC4E, 16'hEC6E, 16'h3521, 16'h0501, 16'h13BE, 16'hEE08};
        r2   = '{16'h21C3, 16'hFDF8, 16'hFC4E, 16'hEC6E, 16'h4521, 16'h0501, 16'h13BE, 16'hFE08};
        r3   = '{16'hFE08, 16'hFC6E, 16'hFC4E, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        r4   = '{16'h8000, 16'hFFFF, 16'h8001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        ones = '{default: 16'h0501};

        exp_flat  = '0;
        exp_max   = '0;
        exp_len   = '0;
        exp_valid = 1'b0;

        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);

        // Full row
        sendRow(r1, 8);
        checkOutput("tp1_flat", 128'(tb_if.out_x_flat),
                    128'hEE08_13BE_0501_3521_EC6E_FC4E_FDF8_21C3);
        checkOutput("tp1_max", 128'(tb_if.out_max_x), 128'h3521);
        checkOutput("tp1_len", 128'(tb_if.out_len), 128'd8);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // Equal elements followed immediately by another row
        sendRow(ones, 8);
        checkOutput("tp2_max1", 128'(tb_if.out_max_x), 128'h0501);
        sendRow(r2, 8);
        checkOutput("tp2_max2", 128'(tb_if.out_max_x), 128'h4521);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // Short row
        sendRow(r3, 3);
        checkOutput("tp3_flat", 128'(tb_if.out_x_flat),
                    128'h8000_8000_8000_8000_8000_FC4E_FC6E_FE08);
        checkOutput("tp3_len", 128'(tb_if.out_len), 128'd3);

        // All-negative row then two single-element rows
        sendRow(r4, 3);
        checkOutput("tp4_max", 128'(tb_if.out_max_x), 128'hFFFF);
        applyStimulus(1'b1, 1'b1, 16'h1000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h2000, 1'b1, 1'b0);
        checkOutput("tp4_single_max", 128'(tb_if.out_max_x), 128'h2000);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // en stall mid-row and while the strobe is high
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, r1[i], 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 16'h7777, 1'b1, 1'b0);
        for (int i = 4; i < 8; i++) applyStimulus(1'b1, 1'b1, r1[i], 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // Reset mid-row
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, r2[i], 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("rst_valid", 128'(tb_if.out_valid), 128'd0);
        sendRow(r1, 8);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7),
                          16'($urandom()), ($urandom_range(0, 9) < 2),
                          ($urandom_range(0, 99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
